// File: rtl/countdown_timer.sv
// Half-unit countdown controller feeding digit_printer / fin_printer display switches.
// Optional pause blink of show_digit enabled by defining COUNTDOWN_PAUSE_BLINK_EN.
module countdown_timer #(
  parameter int unsigned HALF_TICK_CYCLES = 50000000,
  parameter int unsigned CNT_W            = 26
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       start_pause,
  output logic [4:0] val,
  output logic       running,
  output logic       done,
  output logic       show_digit,
  output logic       show_fin
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FINISHED} state_e;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(HALF_TICK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [4:0]       val_q, val_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic             show_digit_q, show_digit_d;
  logic             show_fin_q, show_fin_d;
  logic             tick;

`ifdef COUNTDOWN_PAUSE_BLINK_EN
  logic [CNT_W-1:0] blink_q, blink_d;
`endif

  assign tick = (state_q == RUNNING) && (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (load) begin
      // load outranks start_pause and any coincident tick
      val_d   = load_val;
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_pause) begin
            if (val_q != 5'h00) begin
              state_d = RUNNING;
              presc_d = '0;
            end else begin
              state_d = FINISHED;
              done_d  = 1'b1;
            end
          end
        end
        RUNNING: begin
          if (start_pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d = '0;
            if (val_q[4]) begin
              val_d = {1'b0, val_q[3:0]};
            end else if (val_q[3:0] != 4'd0) begin
              val_d = {1'b1, val_q[3:0] - 4'd1};
            end
            if (val_q == 5'h10) begin
              state_d = FINISHED;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (start_pause) begin
            state_d = RUNNING;
          end
        end
        FINISHED: begin
          val_d = 5'h00;
        end
        default: state_d = IDLE;
      endcase
    end

    running_d  = (state_d == RUNNING);
    show_fin_d = (state_d == FINISHED);

`ifdef COUNTDOWN_PAUSE_BLINK_EN
    blink_d      = blink_q;
    show_digit_d = !show_fin_d;
    if (state_d == PAUSED) begin
      // independent blink counter; the frozen main prescaler is never touched
      if (state_q != PAUSED) begin
        blink_d      = '0;
        show_digit_d = 1'b1;
      end else if (blink_q == TICK_LAST) begin
        blink_d      = '0;
        show_digit_d = ~show_digit_q;
      end else begin
        blink_d      = blink_q + 1'b1;
        show_digit_d = show_digit_q;
      end
    end
`else
    show_digit_d = !show_fin_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      val_q        <= '0;
      presc_q      <= '0;
      done_q       <= 1'b0;
      running_q    <= 1'b0;
      show_digit_q <= 1'b1;
      show_fin_q   <= 1'b0;
`ifdef COUNTDOWN_PAUSE_BLINK_EN
      blink_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      val_q        <= val_d;
      presc_q      <= presc_d;
      done_q       <= done_d;
      running_q    <= running_d;
      show_digit_q <= show_digit_d;
      show_fin_q   <= show_fin_d;
`ifdef COUNTDOWN_PAUSE_BLINK_EN
      blink_q      <= blink_d;
`endif
    end
  end

  assign val        = val_q;
  assign running    = running_q;
  assign done       = done_q;
  assign show_digit = show_digit_q;
  assign show_fin   = show_fin_q;

endmodule
